lsu_mem_arbiter: RTL

LSU_MEM_ARBITER -- requirements
Module: lsu_mem_arbiter

---
 rtl/lsu_mem_arbiter_pkg.sv | 14 +
 rtl/lsu_rr_arbiter.sv | 32 +++
 rtl/lsu_mem_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared types and constants for the LSU / debug-port memory arbiter.
package lsu_mem_arbiter_pkg;

  // Arbiter FSM: nothing outstanding, or one granted transaction awaiting rvalid.
  typedef enum logic {
    IDLE        = 1'b0,
    WAIT_RVALID = 1'b1
  } arb_state_e;

  // Port indices as carried in sel_q / owner_q / last_q.
  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/lsu_rr_arbiter.sv
// Two-way pick between the core LSU port and the debug/DMA port.
// A set lock masks the debug port entirely; on a tie, RR_EN selects
// round-robin (the port not granted last wins) or fixed LSU priority.
module lsu_rr_arbiter
  import lsu_mem_arbiter_pkg::*;
#(
  parameter int unsigned RR_EN = 1
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic lock_i,
  input  logic last_i,
  output logic valid_o,
  output logic pick_o
);

  logic req1_eff;

  // Combinational pick; no state lives here.
  always_comb begin
    req1_eff = req1_i & ~lock_i;
    valid_o  = req0_i | req1_eff;
    if (req0_i && req1_eff) begin
      pick_o = (RR_EN != 0) ? ~last_i : PORT_LSU;
    end else if (req1_eff) begin
      pick_o = PORT_DBG;
    end else begin
      pick_o = PORT_LSU;
    end
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Arbitrates the core LSU port and the debug/DMA port onto one memory
// request channel with at most one outstanding transaction.
//
// Handshake: a requester raises req with a payload and holds both until it
// sees its gnt. Toward memory, mem_req_o and its payload stay stable from
// first assertion until mem_gnt_i; a transfer happens in a cycle where
// mem_req_o & mem_gnt_i are both high. Every granted transfer (read or
// write) is answered by exactly one mem_rvalid_i, routed to the owner.
module lsu_mem_arbiter
  import lsu_mem_arbiter_pkg::*;
#(
  parameter int unsigned RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic        p0_lock_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  input  logic [3:0]  p0_be_i,
  output logic        p0_gnt_o,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [31:0] p1_addr_i,
  input  logic [3:0]  p1_be_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p1_gnt_o,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        dbg_state_o
);

  arb_state_e state_q, state_d;
  logic owner_q, owner_d;
  logic last_q, last_d;
  logic lock_q, lock_d;
  logic sel_q, sel_d;
  logic sel_valid_q, sel_valid_d;

  logic arb_valid, arb_pick;
  logic selected, have_sel, can_issue, mem_req, grant, rsp;

  lsu_rr_arbiter #(.RR_EN(RR_EN)) u_rr_arbiter (
    .req0_i  (p0_req_i),
    .req1_i  (p1_req_i),
    .lock_i  (lock_q),
    .last_i  (last_q),
    .valid_o (arb_valid),
    .pick_o  (arb_pick)
  );

  // A held selection freezes the owner; otherwise the arbiter picks fresh.
  // Issue is possible when idle, or when the outstanding response returns.
  always_comb begin
    selected  = sel_valid_q ? sel_q : arb_pick;
    have_sel  = sel_valid_q | arb_valid;
    can_issue = (state_q == IDLE) | mem_rvalid_i;
    mem_req   = rst_n & have_sel & can_issue;
    grant     = mem_req & mem_gnt_i;
    rsp       = rst_n & (state_q == WAIT_RVALID) & mem_rvalid_i;
  end

  // Output muxing; payload is zero whenever no request is presented.
  always_comb begin
    mem_req_o   = mem_req;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (mem_req) begin
      if (selected == PORT_DBG) begin
        mem_we_o    = p1_we_i;
        mem_addr_o  = p1_addr_i;
        mem_wdata_o = p1_wdata_i;
        mem_be_o    = p1_be_i;
      end else begin
        mem_we_o    = p0_we_i;
        mem_addr_o  = p0_addr_i;
        mem_wdata_o = p0_wdata_i;
        mem_be_o    = p0_be_i;
      end
    end
    p0_gnt_o    = grant & (selected == PORT_LSU);
    p1_gnt_o    = grant & (selected == PORT_DBG);
    p0_rvalid_o = rsp & (owner_q == PORT_LSU);
    p1_rvalid_o = rsp & (owner_q == PORT_DBG);
    p0_rdata_o  = rst_n ? mem_rdata_i : '0;
    p1_rdata_o  = rst_n ? mem_rdata_i : '0;
    busy_o      = (state_q == WAIT_RVALID) | mem_req;
    dbg_state_o = logic'(state_q);
  end

  // Next-state: a grant always lands in WAIT_RVALID (even on the response
  // cycle); an ungranted request latches its owner until memory accepts.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    lock_d      = lock_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    if (grant) begin
      state_d     = WAIT_RVALID;
      owner_d     = selected;
      last_d      = selected;
      sel_valid_d = 1'b0;
      if (selected == PORT_LSU) begin
        lock_d = p0_lock_i;
      end
    end else begin
      if (mem_req) begin
        sel_valid_d = 1'b1;
        sel_d       = selected;
      end
      if ((state_q == WAIT_RVALID) && mem_rvalid_i) begin
        state_d = IDLE;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= PORT_LSU;
      last_q      <= PORT_LSU;
      lock_q      <= 1'b0;
      sel_q       <= PORT_LSU;
      sel_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      lock_q      <= lock_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(p0_gnt_o && p1_gnt_o));

  a_payload_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_addr_o) &&
      $stable(mem_wdata_o) && $stable(mem_be_o) && $stable(mem_we_o)));

  a_addr_known: assert property (@(posedge clk) disable iff (!rst_n)
    mem_req_o |-> !$isunknown(mem_addr_o));

  // A response with nothing outstanding is dropped; flag that it happened.
  c_stray_rvalid: cover property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE) && mem_rvalid_i);

endmodule
